// File: rtl/nurse_pkg.sv
// Shared types for the nurse-call scheduler.
// Holds the serving-state encoding and the default bed count.
package nurse_pkg;

    localparam int N_CALL_DEF = 4;

    typedef enum logic [1:0] {
        IDLE,
        RING,
        ESC
    } state_t;

endpackage

// File: rtl/nurse_call_scheduler_blink_timer.sv
// Blink prescaler for the served bed LED and buzzer.
// Restart loads phase=1; toggle pulses once every BLINK_DIV cycles.
module blink_timer #(
    parameter int BLINK_DIV = 25_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic phase,
    output logic toggle
);

    localparam int PW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(BLINK_DIV - 1);

    logic [PW-1:0] cnt;

    assign toggle = ~restart & (cnt == LAST);

    // prescaler wraps at BLINK_DIV-1 and flips the phase on wrap
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (restart) begin
            cnt   <= '0;
            phase <= 1'b1;
        end else if (toggle) begin
            cnt   <= '0;
            phase <= ~phase;
        end else begin
            cnt   <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/nurse_call_scheduler.sv
// Ward nurse-call scheduler: latches bed calls, serves one by
// fixed priority, blinks its LED and escalates on missing ack.
module nurse_call_scheduler
    import nurse_pkg::*;
#(
    parameter int N_CALL          = N_CALL_DEF,
    parameter int BLINK_DIV       = 25_000_000,
    parameter int TIMEOUT_TOGGLES = 20
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_CALL-1:0]         call,
    input  logic                      ack,
    output logic [N_CALL-1:0]         led,
    output logic                      cur_valid,
    output logic [$clog2(N_CALL)-1:0] cur_id,
    output logic                      buzzer,
    output logic                      alarm
);

    localparam int IW = $clog2(N_CALL);
    localparam int CW = $clog2(TIMEOUT_TOGGLES + 1);
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_TOGGLES);

    logic [N_CALL-1:0] call_q;
    logic              ack_q;
    logic [N_CALL-1:0] pending;
    logic [N_CALL-1:0] pend_n;
    logic [N_CALL-1:0] new_call;
    logic              new_ack;
    state_t            state;
    state_t            state_n;
    logic [IW-1:0]     sel;
    logic [IW-1:0]     sel_n;
    logic [IW-1:0]     first_idx;
    logic [CW-1:0]     tcnt;
    logic [CW-1:0]     tcnt_n;
    logic              restart;
    logic              phase;
    logic              phase_n;
    logic              toggle;
    logic [N_CALL-1:0] led_n;

    assign new_call = call & ~call_q;
    assign new_ack  = ack & ~ack_q;
    assign restart  = (state == IDLE) && (pending != '0);

    blink_timer #(
        .BLINK_DIV(BLINK_DIV)
    ) u_blink (
        .clk    (clk),
        .rst    (rst),
        .restart(restart),
        .phase  (phase),
        .toggle (toggle)
    );

    // lowest pending bed wins arbitration
    always_comb begin
        first_idx = '0;
        for (int i = N_CALL - 1; i >= 0; i--) begin
            if (pending[i]) first_idx = IW'(i);
        end
    end

    // next phase and saturating timeout count, mirrored from the timer
    always_comb begin
        phase_n = phase;
        tcnt_n  = tcnt;
        if (restart) begin
            phase_n = 1'b1;
            tcnt_n  = '0;
        end else if (toggle) begin
            phase_n = ~phase;
            if (tcnt != TMAX) tcnt_n = tcnt + 1'b1;
        end
    end

    // serving FSM plus pending update; a new call beats a clearing ack
    always_comb begin
        state_n = state;
        sel_n   = sel;
        pend_n  = pending;
        unique case (state)
            IDLE: begin
                if (pending != '0) begin
                    state_n = RING;
                    sel_n   = first_idx;
                end
            end
            RING: begin
                if (new_ack) state_n = IDLE;
                else if (tcnt_n == TMAX) state_n = ESC;
            end
            ESC: begin
                if (new_ack) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        if (new_ack && state != IDLE) pend_n[sel] = 1'b0;
        pend_n = pend_n | new_call;
    end

    // LED image: steady for queued beds, blinking for the served one
    always_comb begin
        led_n = pend_n;
        if (state_n != IDLE) led_n[sel_n] = phase_n;
    end

    // state, edge-detect history and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            call_q    <= '1;
            ack_q     <= 1'b1;
            pending   <= '0;
            state     <= IDLE;
            sel       <= '0;
            tcnt      <= '0;
            led       <= '0;
            cur_valid <= 1'b0;
            cur_id    <= '0;
            buzzer    <= 1'b0;
            alarm     <= 1'b0;
        end else begin
            call_q    <= call;
            ack_q     <= ack;
            pending   <= pend_n;
            state     <= state_n;
            sel       <= sel_n;
            tcnt      <= tcnt_n;
            led       <= led_n;
            cur_valid <= (state_n != IDLE);
            cur_id    <= (state_n != IDLE) ? sel_n : '0;
            buzzer    <= (state_n == ESC) | ((state_n == RING) & phase_n);
            alarm     <= (state_n == ESC);
        end
    end

endmodule

// File: tb/tb_nurse_call_scheduler.sv
// Bench for nurse_call_scheduler: constant vector table, corner
// sequences and random traffic against a behavioural model.
module tb_nurse_call_scheduler;

    localparam int N   = 4;
    localparam int DIV = 4;
    localparam int TT  = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] call;
    logic       ack;
    logic [3:0] led;
    logic       cur_valid;
    logic [1:0] cur_id;
    logic       buzzer;
    logic       alarm;

    int checks = 0;
    int errors = 0;

    bit [3:0] m_pend;
    bit [3:0] m_prev_call;
    bit       m_prev_ack;
    bit       m_serv;
    int       m_bed;
    int       m_ticks;

    typedef struct {
        logic [3:0] c;
        logic       a;
        logic       r;
        logic [3:0] led;
        logic       v;
        logic [1:0] id;
        logic       bz;
        logic       al;
    } vec_t;

    vec_t tbl[$];

    nurse_call_scheduler #(
        .N_CALL(N),
        .BLINK_DIV(DIV),
        .TIMEOUT_TOGGLES(TT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .call     (call),
        .ack      (ack),
        .led      (led),
        .cur_valid(cur_valid),
        .cur_id   (cur_id),
        .buzzer   (buzzer),
        .alarm    (alarm)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Model: a served bed accumulates ticks since it started ringing;
    // blink phase and escalation are derived from the tick count.
    task automatic model_step(input bit [3:0] c, input bit a, input bit r);
        bit [3:0] nc;
        bit       na;
        nc = c & ~m_prev_call;
        na = a & ~m_prev_ack;
        m_prev_call = c;
        m_prev_ack  = a;
        if (r) begin
            m_pend = '0; m_serv = 0; m_bed = 0; m_ticks = 0;
            m_prev_call = '1; m_prev_ack = 1;
        end else begin
            if (m_serv && na) begin
                m_pend[m_bed] = 0;
                m_serv = 0;
            end else if (m_serv) begin
                m_ticks++;
            end else if (m_pend != 0) begin
                m_serv  = 1;
                m_ticks = 0;
                m_bed   = 0;
                while (!m_pend[m_bed]) m_bed++;
            end
            m_pend = m_pend | nc;
        end
    endtask

    task automatic model_check();
        bit       esc;
        bit       ph;
        bit [3:0] el;
        esc = m_serv && (m_ticks >= TT * DIV);
        ph  = ((m_ticks / DIV) % 2) == 0;
        el  = m_pend;
        if (m_serv) el[m_bed] = ph;
        chk("model_led", int'(led), int'(el));
        chk("model_valid", int'(cur_valid), int'(m_serv));
        chk("model_id", int'(cur_id), m_serv ? m_bed : 0);
        chk("model_buzzer", int'(buzzer), m_serv ? int'(esc | ph) : 0);
        chk("model_alarm", int'(alarm), int'(esc));
    endtask

    task automatic cycle(input logic [3:0] c, input logic a, input logic r);
        call = c;
        ack  = a;
        rst  = r;
        @(posedge clk);
        model_step(c, a, r);
        @(negedge clk);
        model_check();
    endtask

    initial begin
        vec_t  v;
        logic [3:0] rc;
        rst  = 1'b1;
        call = '0;
        ack  = 1'b0;

        tbl.push_back('{4'b0000, 0, 1, 4'b0000, 0, 0, 0, 0});
        tbl.push_back('{4'b0000, 0, 0, 4'b0000, 0, 0, 0, 0});
        tbl.push_back('{4'b0010, 0, 0, 4'b0010, 0, 0, 0, 0});
        tbl.push_back('{4'b0000, 0, 0, 4'b0010, 1, 1, 1, 0});
        tbl.push_back('{4'b0000, 0, 0, 4'b0010, 1, 1, 1, 0});
        tbl.push_back('{4'b0000, 0, 0, 4'b0010, 1, 1, 1, 0});
        tbl.push_back('{4'b0000, 0, 0, 4'b0010, 1, 1, 1, 0});
        tbl.push_back('{4'b0000, 0, 0, 4'b0000, 1, 1, 0, 0});
        tbl.push_back('{4'b0000, 0, 0, 4'b0000, 1, 1, 0, 0});
        tbl.push_back('{4'b0000, 0, 0, 4'b0000, 1, 1, 0, 0});
        tbl.push_back('{4'b0000, 0, 0, 4'b0000, 1, 1, 0, 0});
        tbl.push_back('{4'b0000, 0, 0, 4'b0010, 1, 1, 1, 0});
        tbl.push_back('{4'b0000, 1, 0, 4'b0000, 0, 0, 0, 0});
        tbl.push_back('{4'b0000, 0, 0, 4'b0000, 0, 0, 0, 0});
        tbl.push_back('{4'b1010, 0, 0, 4'b1010, 0, 0, 0, 0});
        tbl.push_back('{4'b0000, 0, 0, 4'b1010, 1, 1, 1, 0});
        tbl.push_back('{4'b0000, 1, 0, 4'b1000, 0, 0, 0, 0});
        tbl.push_back('{4'b0000, 0, 0, 4'b1000, 1, 3, 1, 0});
        tbl.push_back('{4'b0000, 1, 0, 4'b0000, 0, 0, 0, 0});
        tbl.push_back('{4'b0000, 0, 0, 4'b0000, 0, 0, 0, 0});

        for (int i = 0; i < tbl.size(); i++) begin
            v = tbl[i];
            cycle(v.c, v.a, v.r);
            chk($sformatf("tbl%0d_led", i), int'(led), int'(v.led));
            chk($sformatf("tbl%0d_valid", i), int'(cur_valid), int'(v.v));
            chk($sformatf("tbl%0d_id", i), int'(cur_id), int'(v.id));
            chk($sformatf("tbl%0d_buzzer", i), int'(buzzer), int'(v.bz));
            chk($sformatf("tbl%0d_alarm", i), int'(alarm), int'(v.al));
        end

        // bed 2 served, bed 0 calls meanwhile, then escalation
        cycle(4'b0100, 0, 0);
        cycle(4'b0000, 0, 0);
        chk("serve_bed2", int'(cur_id), 2);
        cycle(4'b0000, 0, 0);
        cycle(4'b0001, 0, 0);
        chk("noprempt_id", int'(cur_id), 2);
        chk("queued_led0", int'(led[0]), 1);
        for (int i = 3; i <= 11; i++) cycle(4'b0001, 0, 0);
        chk("pre_esc_alarm", int'(alarm), 0);
        cycle(4'b0001, 0, 0);
        chk("esc_alarm", int'(alarm), 1);
        chk("esc_buzzer", int'(buzzer), 1);
        cycle(4'b0001, 0, 0);
        chk("esc_buzzer_steady", int'(buzzer), 1);
        cycle(4'b0001, 1, 0);
        chk("ack_alarm_off", int'(alarm), 0);
        chk("ack_bed2_clear", int'(led), 4'b0001);
        cycle(4'b0001, 0, 0);
        chk("next_bed0", int'(cur_id), 0);
        chk("next_valid", int'(cur_valid), 1);

        // escalate with three beds pending, then reset mid-ESC
        cycle(4'b0000, 0, 0);
        cycle(4'b0110, 0, 0);
        for (int i = 3; i <= 12; i++) cycle(4'b0110, 0, 0);
        chk("esc3_alarm", int'(alarm), 1);
        cycle(4'b0110, 0, 1);
        chk("rst_led", int'(led), 0);
        chk("rst_alarm", int'(alarm), 0);
        chk("rst_valid", int'(cur_valid), 0);
        for (int i = 0; i < 3; i++) cycle(4'b0110, 0, 0);
        chk("held_no_pending", int'(led), 0);
        chk("held_idle", int'(cur_valid), 0);
        cycle(4'b0110, 1, 0);
        chk("ack_idle_ignored", int'(cur_valid), 0);
        cycle(4'b0000, 0, 0);

        // ack and re-call of the served bed in the same cycle
        cycle(4'b0010, 0, 0);
        cycle(4'b0000, 0, 0);
        cycle(4'b0010, 1, 0);
        chk("setwins_led", int'(led), 4'b0010);
        chk("setwins_idle", int'(cur_valid), 0);
        cycle(4'b0010, 0, 0);
        chk("reserve_valid", int'(cur_valid), 1);
        chk("reserve_id", int'(cur_id), 1);
        cycle(4'b0000, 1, 0);
        cycle(4'b0000, 0, 0);

        // random traffic against the model
        rc = '0;
        for (int i = 0; i < 3000; i++) begin
            for (int b = 0; b < N; b++)
                if ($urandom_range(0, 9) == 0) rc[b] = ~rc[b];
            cycle(rc, $urandom_range(0, 5) == 0, $urandom_range(0, 299) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nurse_call_scheduler.md
# nurse_call_scheduler

Controller for the ward nurse-call panel. It latches the 4 bed call buttons into pending requests and picks one active call at a time by fixed priority. It drives the per-bed LEDs (blinking for the call being served, steady for queued calls) and a buzzer, and escalates to an alarm when the nurse station does not acknowledge in time. It sits between the raw `call` buttons and the LED/buzzer outputs of the nurse-calling design, replacing direct button-to-LED wiring.

## Interface
Parameters:
- `N_CALL`, 4: number of beds / call inputs.
- `BLINK_DIV`, 25_000_000: clk cycles per blink half-period.
- `TIMEOUT_TOGGLES`, 20: blink toggles in RING before escalation.

Ports:
- `clk` input 1: single system clock; all logic on posedge.
- `rst` input 1: synchronous, active-high reset.
- `call` input N_CALL: bed buttons; level, already synchronous to `clk`.
- `ack` input 1: nurse-station acknowledge button; level, synchronous.
- `led` output N_CALL: per-bed indicator.
- `cur_valid` output 1: a call is being served (state RING or ESC).
- `cur_id` output $clog2(N_CALL): index of the served call; 0 when `cur_valid`=0.
- `buzzer` output 1: audible indication.
- `alarm` output 1: escalation flag.

## Operation
- **Edge detect.**
  - `call_q`/`ack_q` register previous inputs.
  - A new call on bed i is `call[i] & ~call_q[i]`; a new ack is `ack & ~ack_q`.
  - Reset loads `call_q` and `ack_q` with all-ones, so buttons held through reset are not new events.
- **Pending register.**
  - A new call on bed i sets `pending[i]`.
  - A new call on an already-pending bed has no effect.
  - On a new ack in RING/ESC, `pending[cur_id]` is cleared.
  - If a new call on `cur_id` arrives in the same cycle as the ack, set wins and the bed stays pending.
- **FSM states:** IDLE, RING, ESC.
  - IDLE: if `pending`≠0, latch `cur_id` = lowest set index, go to RING. Restart the blink timer with phase=1 and timeout count=0.
  - RING: a new ack goes to IDLE. Otherwise, when the timeout count reaches TIMEOUT_TOGGLES, go to ESC.
  - ESC: a new ack goes to IDLE.
  - There is no preemption. A higher-priority call arriving in RING/ESC waits in `pending`.
  - A new ack in IDLE is ignored.
- **Outputs** (registered, updated each cycle from next-state values):
  - `led[i]` = `pending[i]`, except `led[cur_id]` = `blink_phase` while `cur_valid`.
  - `buzzer` = `blink_phase` in RING, 1 in ESC, 0 in IDLE.
  - `alarm` = 1 only in ESC.
- **Widths.**
  - Prescaler: $clog2(BLINK_DIV) bits, wraps at BLINK_DIV-1.
  - Timeout counter: $clog2(TIMEOUT_TOGGLES+1) bits, saturates at TIMEOUT_TOGGLES.

## Timing
- Reset values: `led`=0, `cur_valid`=0, `cur_id`=0, `buzzer`=0, `alarm`=0, `pending`=0, state IDLE, prescaler 0, phase 0.
- A call sampled high at edge k (low at k-1) sets `pending` at edge k.
- The FSM leaves IDLE at edge k+1, so `cur_valid`/`led`/`buzzer` are visible after edge k+1. Latency is 2 cycles from the input change to the outputs.
- In RING, `blink_phase` toggles every BLINK_DIV cycles from entry, and each toggle increments the timeout count.
- ESC is entered TIMEOUT_TOGGLES×BLINK_DIV cycles after RING entry.
- Ack sampled at edge m: state is IDLE and the pending bit is cleared at edge m. Re-arbitration to the next pending call happens at edge m+1.
- `rst` asserted mid-operation clears everything at that edge, including pending calls and any alarm.

## Structure
- Package `nurse_pkg`: state enum (IDLE, RING, ESC) and the default N_CALL constant.
- Sub-module `blink_timer`:
  - Inputs: `clk`, `rst`, `restart`.
  - Outputs: `phase`, 1-cycle `toggle` pulse.
  - Parameter: BLINK_DIV.
- The top module holds the edge detect, pending register, priority encoder, FSM, timeout counter and output registers.

## Test plan
Run with BLINK_DIV=4, TIMEOUT_TOGGLES=3.
- `call`=0010 for 1 cycle → after 2 cycles `cur_valid`=1, `cur_id`=1; `led[1]` toggles every 4 cycles starting at 1; `buzzer` follows it.
- `call`=1010 simultaneously → `cur_id`=1; `led`=1000 | blink on bit 1. Ack → next cycle IDLE, following cycle `cur_id`=3.
- Serving bed 2 when bed 0 calls → `cur_id` stays 2 until ack, then becomes 0; `led[0]`=1 steady meanwhile.
- No ack for 12 cycles after RING entry → `alarm`=1, `buzzer`=1 steady. Ack → `alarm`=0, bed cleared.
- `call[1]` held high through reset release → no pending. Ack in IDLE → no change. New call on `cur_id` in the same cycle as ack → bed re-served.
- `rst` pulse in ESC with 3 pending → all outputs 0 next cycle; `pending`=0.
